muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal: 8..64, even).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request; sampled only when ready=1.
REQ-005 Port: Funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port: SrcA  input  WIDTH  operand A (multiplicand/dividend).
REQ-007 Port: SrcB  input  WIDTH  operand B (multiplier/divisor).
REQ-008 Port: ready  output  1  high when state is IDLE or DONE.
REQ-009 Port: busy  output  1  high when state is BUSY.
REQ-010 Port: valid  output  1  one-cycle pulse; Result is valid in this cycle.
REQ-011 Port: Result  output  WIDTH  registered result; holds its value until the next completion.

Function
REQ-012 FSM states: IDLE, BUSY, DONE; exactly one state active.
REQ-013 IDLE/DONE & start=1: latch Funct3, SrcA, SrcB, load iteration counter to WIDTH, go to BUSY.
REQ-014 IDLE & start=0: stay in IDLE; DONE & start=0: go to IDLE.
REQ-015 BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle; counter decrements by 1; at counter=1, go to DONE.
REQ-016 Latency: start accepted at edge t -> valid=1 during cycle t+WIDTH+1.
REQ-017 start while BUSY: ignored, no effect on the operation in flight; operand changes while BUSY have no effect.
REQ-018 start in DONE cycle: accepted (back-to-back); valid pulses for that DONE cycle only.
REQ-019 MUL: low WIDTH bits of product; MULH: high WIDTH bits signed x signed; MULHSU: high WIDTH bits signed(A) x unsigned(B); MULHU: high WIDTH bits unsigned x unsigned.
REQ-020 DIV/REM: signed, quotient rounds toward zero, remainder sign = dividend sign; DIVU/REMU: unsigned.
REQ-021 Divide by zero: DIV/DIVU -> all ones; REM/REMU -> SrcA.
REQ-022 Signed overflow (DIV/REM, SrcA = most-negative, SrcB = -1): DIV -> SrcA; REM -> 0.
REQ-023 Internal product/remainder datapath is 2*WIDTH bits; no intermediate truncation.
REQ-024 Result updates only on the BUSY->DONE transition (or the early-out transition per REQ-028).

Reset
REQ-025 reset=1 at an edge: state=IDLE, Result=0, valid=0, busy=0, ready=1, counter=0.
REQ-026 reset during BUSY abandons the operation; no valid pulse is generated for it.
REQ-027 reset has priority over start in the same cycle.

Configuration
REQ-028 Macro MULDIV_EARLY_OUT_EN defined: divide by zero (REQ-021) and signed overflow (REQ-022) go directly IDLE/DONE -> DONE, with valid during cycle t+1.
REQ-029 Macro MULDIV_EARLY_OUT_EN undefined: these cases take the full WIDTH+1 latency; Result values are identical in both builds.

Verification (WIDTH=32)
REQ-030 MUL, A=0x0000_0007, B=0xFFFF_FFFD -> valid at t+33, Result=0xFFFF_FFEB; MULH same operands -> 0xFFFF_FFFF; MULHU same operands -> 0x0000_0006.
REQ-031 DIV, A=0xFFFF_FFF9 (-7), B=2 -> Result=0xFFFF_FFFD; REM, same operands -> 0xFFFF_FFFF; DIVU, A=100, B=7 -> 14.
REQ-032 DIVU, B=0, A=0x1234 -> Result=0xFFFF_FFFF; REMU, same operands -> 0x1234; DIV, A=0x8000_0000, B=0xFFFF_FFFF -> 0x8000_0000; all at t+33 without the macro and t+1 with MULDIV_EARLY_OUT_EN.
REQ-033 Back-to-back: second start asserted in the DONE cycle -> second valid exactly 33 cycles after the first; a start pulse mid-BUSY -> no extra valid, first Result unchanged.
REQ-034 reset asserted at BUSY cycle 10 -> next cycle state=IDLE, ready=1, Result=0, and no valid pulse within the following 40 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative integer multiply / divide unit for the RISC-V M-extension op set.
// A request is taken whenever the unit is ready (IDLE or DONE). A multiply
// runs one shift-add step per cycle and a divide runs one restoring-subtract
// step per cycle, for WIDTH cycles. The result is then presented for one
// cycle with valid=1. Signed operations are carried out on operand
// magnitudes, and the sign is applied to the final 2*WIDTH-bit value.
//
// Parameters
//   WIDTH   operand/result width in bits (8..64, even), default 32
//
// Ports
//   clk     clock; all state updates on the rising edge
//   reset   synchronous, active-high reset
//   start   request; sampled only while ready=1
//   Funct3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                      100 DIV, 101 DIVU, 110 REM,    111 REMU
//   SrcA    operand A (multiplicand / dividend)
//   SrcB    operand B (multiplier / divisor)
//   ready   high in IDLE or DONE
//   busy    high in BUSY
//   valid   one-cycle pulse; Result is valid in that cycle
//   Result  registered result; holds its value until the next completion
//
// Build option
//   MULDIV_EARLY_OUT_EN  when defined, divide-by-zero and signed-overflow
//                        requests skip the iteration and complete in the
//                        cycle after acceptance. The result values are the
//                        same in both builds.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] Result
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]    CNT_LOAD  = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic EARLY_OUT_C = 1'b1;
`else
    localparam logic EARLY_OUT_C = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Magnitude of a value when it is interpreted as signed and is negative.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        logic [WIDTH-1:0] m;
        if (sgn && v[WIDTH-1]) begin
            m = -v;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // FSM
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;

    // Latched request and iteration datapath
    logic [2:0]       op_r;
    logic [W2-1:0]    acc_r;        // product accumulator, or {remainder, quotient}
    logic [W2-1:0]    mcand_r;      // multiplicand, shifted left each step
    logic [WIDTH-1:0] opb_r;        // multiplier (shifted right) or divisor (static)
    logic             qneg_r;       // negate product / quotient at the end
    logic             rneg_r;       // negate remainder at the end
    logic             spec_r;       // divide-by-zero or signed overflow
    logic [WIDTH-1:0] spec_val_r;   // fixed result for those cases

    // Request decode
    logic             accept_s;
    logic             a_sgn_s;
    logic             b_sgn_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic             div0_s;
    logic             ovf_s;
    logic             special_s;
    logic             early_s;
    logic [WIDTH-1:0] special_val_s;

    // Step logic and finalisation
    logic [W2-1:0]    mul_nxt_s;
    logic [WIDTH:0]   div_upper_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] div_diff_s;
    logic [W2-1:0]    div_nxt_s;
    logic [W2-1:0]    acc_nxt_s;
    logic [W2-1:0]    prod_fix_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;
    logic [WIDTH-1:0] result_fin_s;

    assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    // Which operands are taken as signed for the requested op.
    always_comb begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
        case (Funct3)
            OP_MULH: begin
                a_sgn_s = 1'b1;
                b_sgn_s = 1'b1;
            end
            OP_MULHSU: begin
                a_sgn_s = 1'b1;
                b_sgn_s = 1'b0;
            end
            OP_DIV, OP_REM: begin
                a_sgn_s = 1'b1;
                b_sgn_s = 1'b1;
            end
            default: begin
                a_sgn_s = 1'b0;
                b_sgn_s = 1'b0;
            end
        endcase
    end

    assign a_mag_s   = magnitude(SrcA, a_sgn_s);
    assign b_mag_s   = magnitude(SrcB, b_sgn_s);
    assign div0_s    = Funct3[2] && (SrcB == ALL_ZEROS);
    assign ovf_s     = ((Funct3 == OP_DIV) || (Funct3 == OP_REM)) &&
                       (SrcA == MIN_NEG) && (SrcB == ALL_ONES);
    assign special_s = div0_s || ovf_s;
    assign early_s   = special_s && EARLY_OUT_C;

    // Fixed results for divide-by-zero and signed overflow. Funct3[1] set
    // selects the remainder variants (REM/REMU).
    always_comb begin
        special_val_s = ALL_ZEROS;
        if (div0_s) begin
            special_val_s = Funct3[1] ? SrcA : ALL_ONES;
        end else if (ovf_s) begin
            special_val_s = Funct3[1] ? ALL_ZEROS : SrcA;
        end else begin
            special_val_s = ALL_ZEROS;
        end
    end

    // One shift-add multiply step: add the shifted multiplicand when the
    // current multiplier LSB is set.
    assign mul_nxt_s = opb_r[0] ? (acc_r + mcand_r) : acc_r;

    // One restoring divide step on {remainder, quotient}. The shifted partial
    // remainder needs WIDTH+1 bits for the compare; after a subtract it is
    // below the divisor, so the low WIDTH bits of the difference are exact.
    assign div_upper_s = acc_r[W2-1:WIDTH-1];
    assign div_ge_s    = (div_upper_s >= {1'b0, opb_r});
    assign div_diff_s  = div_upper_s[WIDTH-1:0] - opb_r;
    assign div_nxt_s   = div_ge_s ? {div_diff_s, acc_r[WIDTH-2:0], 1'b1}
                                  : {div_upper_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};

    assign acc_nxt_s  = op_r[2] ? div_nxt_s : mul_nxt_s;

    // Sign correction applied to the value produced by the final step.
    assign prod_fix_s = qneg_r ? -acc_nxt_s : acc_nxt_s;
    assign quo_s      = acc_nxt_s[WIDTH-1:0];
    assign rem_s      = acc_nxt_s[W2-1:WIDTH];
    assign quo_fix_s  = qneg_r ? -quo_s : quo_s;
    assign rem_fix_s  = rneg_r ? -rem_s : rem_s;

    // Select the architectural result for the latched op.
    always_comb begin
        result_fin_s = ALL_ZEROS;
        if (spec_r) begin
            result_fin_s = spec_val_r;
        end else begin
            case (op_r)
                OP_MUL:                       result_fin_s = prod_fix_s[WIDTH-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: result_fin_s = prod_fix_s[W2-1:WIDTH];
                OP_DIV, OP_DIVU:              result_fin_s = quo_fix_s;
                OP_REM, OP_REMU:              result_fin_s = rem_fix_s;
                default:                      result_fin_s = ALL_ZEROS;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s = early_s ? ST_DONE : ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready   <= (state_nxt_s != ST_BUSY);
            busy    <= (state_nxt_s == ST_BUSY);
            valid   <= (state_nxt_s == ST_DONE);
        end
    end

    // Request capture, per-cycle iteration and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r      <= {CW{1'b0}};
            op_r       <= 3'b000;
            acc_r      <= {W2{1'b0}};
            mcand_r    <= {W2{1'b0}};
            opb_r      <= ALL_ZEROS;
            qneg_r     <= 1'b0;
            rneg_r     <= 1'b0;
            spec_r     <= 1'b0;
            spec_val_r <= ALL_ZEROS;
            Result     <= ALL_ZEROS;
        end else if (accept_s) begin
            op_r       <= Funct3;
            mcand_r    <= {ALL_ZEROS, a_mag_s};
            opb_r      <= b_mag_s;
            // Divide starts with the dividend in the quotient half.
            acc_r      <= Funct3[2] ? {ALL_ZEROS, a_mag_s} : {W2{1'b0}};
            qneg_r     <= (a_sgn_s & SrcA[WIDTH-1]) ^ (b_sgn_s & SrcB[WIDTH-1]);
            rneg_r     <= a_sgn_s & SrcA[WIDTH-1];
            spec_r     <= special_s;
            spec_val_r <= special_val_s;
            if (early_s) begin
                cnt_r  <= {CW{1'b0}};
                Result <= special_val_s;
            end else begin
                cnt_r  <= CNT_LOAD;
            end
        end else if (state_r == ST_BUSY) begin
            acc_r   <= acc_nxt_s;
            mcand_r <= {mcand_r[W2-2:0], 1'b0};
            opb_r   <= op_r[2] ? opb_r : {1'b0, opb_r[WIDTH-1:1]};
            cnt_r   <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
                Result <= result_fin_s;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed and random stimulus for muldiv_unit (WIDTH=32). Each request
// pushes its expected result and completion cycle to a scoreboard queue; a
// monitor pops and compares whenever valid is seen.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
    localparam logic [W-1:0] MINN = 32'h8000_0000;
    localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   Funct3 = 3'b000;
    logic [W-1:0] SrcA = 32'h0;
    logic [W-1:0] SrcB = 32'h0;
    logic         ready, busy, valid;
    logic [W-1:0] Result;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .ready  (ready),
        .busy   (busy),
        .valid  (valid),
        .Result (Result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   valid_cnt = 0;

    function automatic logic [W-1:0] ref_res(input logic [2:0] f, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [63:0] sa, sb, sp, sq;
        logic [63:0]        ua, ub, up;
        logic [W-1:0]       r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        r  = 32'h0;
        case (f)
            MUL:    begin up = ua * ub; r = up[31:0]; end
            MULH:   begin sp = sa * sb; r = sp[63:32]; end
            MULHSU: begin sp = sa * $signed(ub); r = sp[63:32]; end
            MULHU:  begin up = ua * ub; r = up[63:32]; end
            DIV: begin
                if (b == 32'h0) r = ONES;
                else if (a == MINN && b == ONES) r = a;
                else begin sq = sa / sb; r = sq[31:0]; end
            end
            DIVU: r = (b == 32'h0) ? ONES : a / b;
            REM: begin
                if (b == 32'h0) r = a;
                else if (a == MINN && b == ONES) r = 32'h0;
                else begin sq = sa % sb; r = sq[31:0]; end
            end
            default: r = (b == 32'h0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
        bit sp;
        sp = (f[2] && b == 32'h0) || ((f == DIV || f == REM) && a == MINN && b == ONES);
        return (sp && EO) ? 1 : W + 1;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one request at the current negedge; scramble inputs afterwards.
    task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input string tag);
        exp_t e;
        Funct3 = f; SrcA = a; SrcB = b; start = 1'b1;
        e.tag = tag; e.res = r; e.cyc = cyc + lat_of(f, a, b);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        Funct3 = 3'($urandom_range(0, 7));
        SrcA = $urandom;
        SrcB = $urandom;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (sb_q.size() == 0) else begin
            bad++;
            $error("FAIL %s_timeout: observed pending=%0d expected pending=0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] r, input string tag);
        issue(f, a, b, r, tag);
        drain(tag);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor: every valid pulse must match the oldest request.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (valid === 1'b1) begin
            valid_cnt++;
            total++;
            assert (sb_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_valid: observed valid=1 at cycle %0d expected no pulse", cyc);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk({e.tag, "_result"}, Result, e.res);
                total++;
                assert (cyc === e.cyc) else begin
                    bad++;
                    $error("FAIL %s_latency: observed cycle=%0d expected cycle=%0d", e.tag, cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   f;
        logic [W-1:0] a, b;
        int           vc0;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", W'(ready), 32'h1);
        chk("rst_busy", W'(busy), 32'h0);
        chk("rst_valid", W'(valid), 32'h0);
        chk("rst_result", Result, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Multiply variants
        op(MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        op(MULH,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "mulh");
        op(MULHU,  32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, "mulhu");
        op(MULHSU, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, "mulhsu");

        // Divide variants
        op(DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div");
        op(REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem");
        op(DIVU, 32'd100,       32'd7,         32'd14,        "divu");
        op(REMU, 32'd100,       32'd7,         32'd2,         "remu");

        // Divide by zero and signed overflow
        op(DIVU, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, "divu_z");
        op(REMU, 32'h0000_1234, 32'h0, 32'h0000_1234, "remu_z");
        op(DIV,  32'hFFFF_FF00, 32'h0, 32'hFFFF_FFFF, "div_z");
        op(REM,  32'hFFFF_FF00, 32'h0, 32'hFFFF_FF00, "rem_z");
        op(DIV,  MINN, ONES, MINN,       "div_ovf");
        op(REM,  MINN, ONES, 32'h0,      "rem_ovf");

        // Random operations against the reference model
        for (int i = 0; i < 24; i++) begin
            f = 3'(i % 8);
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (i % 5 == 0) a = MINN;
            op(f, a, b, ref_res(f, a, b), "rand");
        end

        // Back-to-back: second start in the DONE cycle
        issue(MUL, 32'd3, 32'd5, 32'd15, "b2b_first");
        for (int n = 0; n < 100 && valid !== 1'b1; n++) @(negedge clk);
        issue(DIVU, 32'd1000, 32'd3, 32'd333, "b2b_second");
        drain("b2b");

        // start pulse while BUSY must be ignored
        @(negedge clk);
        vc0 = valid_cnt;
        issue(MUL, 32'h0000_1111, 32'h0000_0010, 32'h0001_1110, "midbusy");
        repeat (5) @(negedge clk);
        Funct3 = DIV; SrcA = 32'h100; SrcB = 32'h2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("midbusy");
        repeat (3) @(negedge clk);
        chk("midbusy_hold", Result, 32'h0001_1110);
        chk("midbusy_pulses", 32'(valid_cnt - vc0), 32'h1);
        chk("midbusy_ready", W'(ready), 32'h1);

        // Reset during BUSY abandons the operation
        issue(MUL, 32'd5, 32'd9, 32'd45, "rst_busy_op");
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", W'(busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        chk("post_rst_ready", W'(ready), 32'h1);
        chk("post_rst_busy", W'(busy), 32'h0);
        chk("post_rst_result", Result, 32'h0);
        vc0 = valid_cnt;
        repeat (40) @(negedge clk);
        chk("post_rst_no_valid", 32'(valid_cnt - vc0), 32'h0);

        // Recovery after reset
        op(MULHU, ONES, ONES, 32'hFFFF_FFFE, "recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
